// File: rtl/wb_ram_slave_if.sv
// Pipelined Wishbone B4 bundle shared by the RAM responder and its initiators.
// SLAVE is the responder view and MASTER is the initiator view.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;

    modport SLAVE (
        input  cyc, stb, we, lock, addr, sel, wdata,
        output rdata, ack, stall
    );

    modport MASTER (
        output cyc, stb, we, lock, addr, sel, wdata,
        input  rdata, ack, stall
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined RAM responder: one request per cycle, in-order acks after a
// fixed LATENCY, and an optional one-cycle stall after every STALL_PERIOD accepted beats.
module wb_ram_slave #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int LATENCY      = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    wishbone_if.SLAVE  wb_if,
    output logic       busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;
    localparam logic [CW-1:0] PERIOD = CW'(STALL_PERIOD);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    stall_state_e        state_q, state_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                accept;
    logic [AW-1:0]       word_idx;
    logic [31:0]         mem_q [DEPTH_WORDS];
    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [31:0]         dat_q [LATENCY];
    logic [31:0]         dat_d [LATENCY];
    logic                unused_inputs;

    // Handshake: a beat transfers on a rising edge where cyc & stb are high and the
    // registered stall is low; the initiator must hold the request while stall is high.
    assign accept   = wb_if.cyc & wb_if.stb & (state_q == ST_COUNT);
    assign word_idx = wb_if.addr[AW+1:2];

    assign unused_inputs = ^{wb_if.lock, wb_if.addr[31:AW+2], wb_if.addr[1:0]};

    // Stall FSM: state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_COUNT;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Stall FSM: next state
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_COUNT: begin
                if (accept && (STALL_PERIOD != 0)) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_d == PERIOD) begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                beat_cnt_d = '0;
                state_d    = ST_COUNT;
            end
            default: begin
                beat_cnt_d = '0;
                state_d    = ST_COUNT;
            end
        endcase
    end

    // Stall FSM: outputs (registered state only, no input reaches stall)
    always_comb begin
        wb_if.stall = (state_q == ST_STALL);
    end

    // RAM contents survive reset; only byte lanes with sel set are written.
    always_ff @(posedge clk_i) begin
        if (accept && wb_if.we) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_if.sel[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wb_if.wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            dat_d[i] = '0;
        end
        vld_d    = '0;
        vld_d[0] = accept;
        dat_d[0] = (accept && !wb_if.we) ? mem_q[word_idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        // Dropping cyc abandons everything still in flight.
        if (!wb_if.cyc) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign wb_if.ack   = vld_q[LATENCY-1] & wb_if.cyc;
    assign wb_if.rdata = wb_if.ack ? dat_q[LATENCY-1] : 32'h0;
    assign busy_o      = |vld_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances (plain, deep pipeline, periodic stall)
// share one stimulus set, with cyc steered to the instance under test.
module tb_wb_ram_slave;

    logic        clk;
    logic        rstn;
    logic        cyc_r, stb_r, we_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  sel_r;
    int          dut_sel;

    logic        ack_m, stall_m, busy_m;
    logic [31:0] rdata_m;
    logic        busy_a, busy_b, busy_c;

    int n_vec = 0;
    int n_err = 0;

    wishbone_if wb_a ();
    wishbone_if wb_b ();
    wishbone_if wb_c ();

    assign wb_a.cyc = cyc_r && (dut_sel == 0);
    assign wb_b.cyc = cyc_r && (dut_sel == 1);
    assign wb_c.cyc = cyc_r && (dut_sel == 2);
    assign wb_a.stb = stb_r;   assign wb_b.stb = stb_r;   assign wb_c.stb = stb_r;
    assign wb_a.we = we_r;     assign wb_b.we = we_r;     assign wb_c.we = we_r;
    assign wb_a.lock = 1'b0;   assign wb_b.lock = 1'b0;   assign wb_c.lock = 1'b0;
    assign wb_a.addr = addr_r; assign wb_b.addr = addr_r; assign wb_c.addr = addr_r;
    assign wb_a.sel = sel_r;   assign wb_b.sel = sel_r;   assign wb_c.sel = sel_r;
    assign wb_a.wdata = wdata_r;
    assign wb_b.wdata = wdata_r;
    assign wb_c.wdata = wdata_r;

    wb_ram_slave #(.DEPTH_WORDS(1024), .LATENCY(1), .STALL_PERIOD(0)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .wb_if(wb_a), .busy_o(busy_a)
    );
    wb_ram_slave #(.DEPTH_WORDS(1024), .LATENCY(3), .STALL_PERIOD(0)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .wb_if(wb_b), .busy_o(busy_b)
    );
    wb_ram_slave #(.DEPTH_WORDS(1024), .LATENCY(1), .STALL_PERIOD(2)) dut_c (
        .clk_i(clk), .rstn_i(rstn), .wb_if(wb_c), .busy_o(busy_c)
    );

    always_comb begin
        case (dut_sel)
            1: begin
                ack_m = wb_b.ack; rdata_m = wb_b.rdata; stall_m = wb_b.stall; busy_m = busy_b;
            end
            2: begin
                ack_m = wb_c.ack; rdata_m = wb_c.rdata; stall_m = wb_c.stall; busy_m = busy_c;
            end
            default: begin
                ack_m = wb_a.ack; rdata_m = wb_a.rdata; stall_m = wb_a.stall; busy_m = busy_a;
            end
        endcase
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
        cyc_r = 1'b1; stb_r = 1'b1; we_r = w; addr_r = a; sel_r = s; wdata_r = d;
    endtask

    task automatic idle(input logic c);
        cyc_r = c; stb_r = 1'b0; we_r = 1'b0; addr_r = '0; sel_r = '0; wdata_r = '0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pre_addr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] pre_data [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h55};
    logic [31:0] rd_addr  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h1010};
    logic        st_stall [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        st_ack   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int beat;
        int acks;
        rstn = 1'b0;
        dut_sel = 0;
        idle(1'b0);
        #2;
        for (int d = 0; d < 3; d++) begin
            dut_sel = d;
            #1;
            check("rst_ack", ack_m, 0);
            check("rst_rdata", rdata_m, 0);
            check("rst_stall", stall_m, 0);
            check("rst_busy", busy_m, 0);
        end
        @(negedge clk);
        rstn = 1'b1;
        nxt();

        // full write then read, LATENCY=1
        dut_sel = 0;
        req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        mid(); check("t1_pre_ack", ack_m, 0);
        nxt();
        req(1'b0, 32'h10, 4'h0, 32'h0);
        mid(); check("t1_wr_ack", ack_m, 1); check("t1_wr_rdata", rdata_m, 0);
        nxt();
        idle(1'b1);
        mid(); check("t1_rd_ack", ack_m, 1); check("t1_rd_data", rdata_m, 32'hDEADBEEF);
        nxt();
        mid(); check("t1_idle_ack", ack_m, 0); check("t1_idle_rdata", rdata_m, 0);

        // byte-lane write and sel=0 write
        nxt();
        req(1'b1, 32'h10, 4'b0100, 32'h00AA0000);
        nxt();
        req(1'b0, 32'h10, 4'h0, 32'h0);
        mid(); check("bl_wr_ack", ack_m, 1);
        nxt();
        req(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        mid(); check("bl_rd_ack", ack_m, 1); check("bl_rd_data", rdata_m, 32'hDEAABEEF);
        nxt();
        req(1'b0, 32'h10, 4'h0, 32'h0);
        mid(); check("bl_sel0_ack", ack_m, 1);
        nxt();
        idle(1'b1);
        mid(); check("bl_rd2_data", rdata_m, 32'hDEAABEEF);
        nxt();
        idle(1'b0);
        nxt();

        // pipelined reads with alias, LATENCY=3
        dut_sel = 1;
        for (int i = 0; i < 5; i++) begin
            req(1'b1, pre_addr[i], 4'hF, pre_data[i]);
            nxt();
        end
        idle(1'b1);
        repeat (4) nxt();
        for (int k = 0; k < 8; k++) begin
            if (k < 5) req(1'b0, rd_addr[k], 4'h0, 32'h0);
            else idle(1'b1);
            mid();
            check($sformatf("pl_ack_%0d", k), ack_m, (k >= 3) ? 32'd1 : 32'd0);
            if (k >= 3) check($sformatf("pl_data_%0d", k), rdata_m, pre_data[k-3]);
            nxt();
        end

        // abort two reads in flight
        req(1'b0, 32'h0, 4'h0, 32'h0);
        nxt();
        req(1'b0, 32'h4, 4'h0, 32'h0);
        nxt();
        idle(1'b0);
        mid(); check("ab_busy_before", busy_m, 1); check("ab_ack_x2", ack_m, 0);
        nxt();
        mid(); check("ab_busy_after", busy_m, 0); check("ab_ack_x3", ack_m, 0);
        nxt();
        idle(1'b1);
        for (int k = 0; k < 4; k++) begin
            mid(); check($sformatf("ab_noack_%0d", k), ack_m, 0);
            nxt();
        end
        req(1'b0, 32'h8, 4'h0, 32'h0);
        nxt();
        idle(1'b1);
        mid(); check("ab_new_y1", ack_m, 0);
        nxt();
        mid(); check("ab_new_y2", ack_m, 0);
        nxt();
        mid(); check("ab_new_ack", ack_m, 1); check("ab_new_data", rdata_m, 32'h3);
        nxt();
        idle(1'b0);
        nxt();

        // periodic stall, STALL_PERIOD=2
        dut_sel = 2;
        beat = 0;
        acks = 0;
        for (int k = 0; k < 7; k++) begin
            if (beat < 4) req(1'b1, 32'h20 + 32'(4 * beat), 4'hF, 32'hA0 + 32'(beat));
            else idle(1'b1);
            mid();
            check($sformatf("st_stall_%0d", k), stall_m, 32'(st_stall[k]));
            check($sformatf("st_ack_%0d", k), ack_m, 32'(st_ack[k]));
            if (ack_m) acks++;
            if (beat < 4 && !stall_m) beat++;
            nxt();
        end
        check("st_beats", beat, 4);
        check("st_ack_count", acks, 4);
        req(1'b0, 32'h2C, 4'h0, 32'h0);
        mid(); check("st_rb_stall", stall_m, 0);
        nxt();
        idle(1'b1);
        mid(); check("st_rb_ack", ack_m, 1); check("st_rb_data", rdata_m, 32'hA3);
        nxt();
        idle(1'b0);
        nxt();

        // asynchronous reset with requests in flight, LATENCY=3
        dut_sel = 1;
        req(1'b0, 32'h4, 4'h0, 32'h0);
        nxt();
        req(1'b0, 32'hC, 4'h0, 32'h0);
        nxt();
        req(1'b0, 32'h0, 4'h0, 32'h0);
        nxt();
        idle(1'b1);
        #1;
        check("ar_ack_before", ack_m, 1);
        check("ar_busy_before", busy_m, 1);
        rstn = 1'b0;
        #1;
        check("ar_ack_async", ack_m, 0);
        check("ar_rdata_async", rdata_m, 0);
        check("ar_stall_async", stall_m, 0);
        check("ar_busy_async", busy_m, 0);
        nxt();
        @(negedge clk);
        rstn = 1'b1;
        nxt();
        for (int k = 0; k < 4; k++) begin
            mid(); check($sformatf("ar_dropped_%0d", k), ack_m, 0);
            nxt();
        end
        req(1'b0, 32'h4, 4'h0, 32'h0);
        nxt();
        idle(1'b1);
        nxt();
        nxt();
        mid(); check("ar_post_ack", ack_m, 1); check("ar_post_data", rdata_m, 32'h2);
        nxt();
        idle(1'b0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Pipelined Wishbone B4 responder backed by a word-organised on-chip RAM. It sits on the slave side of the data port, answering the core's load/store requests. It also serves as the memory model for LSU-side verification. It accepts one request per cycle, returns acks in order after a fixed, configurable latency, and can insert periodic stall cycles to exercise the initiator's back-pressure handling.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- LATENCY, 1: cycles from request acceptance to ack; legal range 1..4.
- STALL_PERIOD, 0: after every STALL_PERIOD accepted beats, assert stall for one cycle; 0 disables stalling.

- clk_i  input  1  clock; all state updates on the rising edge.
- rstn_i  input  1  reset; asynchronous, active-low.
- wb_if  wishbone_if.SLAVE  —  pipelined Wishbone B4 slave port, carrying the signals below.
- wb_if.cyc / stb / we  input  1 each  cycle, strobe, write enable.
- wb_if.lock  input  1  ignored.
- wb_if.addr  input  32  byte address.
- wb_if.sel  input  4  byte lanes for writes; ignored for reads.
- wb_if.wdata  input  32  write data.
- wb_if.rdata  output  32  read data, valid only while ack is high.
- wb_if.ack  output  1  one-cycle completion strobe, one per accepted request.
- wb_if.stall  output  1  request not accepted this cycle.
- busy_o  output  1  at least one accepted request is still awaiting ack.

## Operation
- **Accept condition:** a request is accepted when `cyc & stb & !stall` is high at a rising edge. At most one request is accepted per cycle.
- **Addressing:**
  - Word index = addr[$clog2(DEPTH_WORDS)+1:2].
  - addr[1:0] and all upper bits are ignored, so out-of-range addresses alias (wrap).
- **Writes:**
  - Each lane i with sel[i]=1 is written with wdata[8i+7:8i] at the accept edge.
  - sel=0 accepts and acks the request but changes nothing.
- **Reads:**
  - The word is sampled at the accept edge.
  - A read accepted one cycle after a write to the same word returns the new data.
- **Response pipeline:**
  - A LATENCY-deep shift register carries a valid bit and read data for each accepted request.
  - Writes carry rdata=0.
  - Acks leave in acceptance order. Back-to-back accepts produce back-to-back acks.
- **Stall generation:**
  - beat_cnt counts accepted beats.
  - When STALL_PERIOD≠0 and beat_cnt==STALL_PERIOD:
    - stall=1 for exactly one cycle, regardless of stb;
    - beat_cnt clears to 0;
    - no request is accepted that cycle.
  - stall is driven from registered state only; there is no combinational path from any input to stall.
- **Abort:**
  - While cyc=0, ack is forced to 0 combinationally.
  - At the next edge with cyc=0, all pipeline valid bits clear.
  - Writes already performed stay in memory.
  - beat_cnt is unaffected by an abort.
- **busy_o:** OR of all pipeline valid bits.
- **No error responses:** err/rty are not generated.

## Timing
- **Reset:** asserting rstn_i immediately drives:
  - ack=0, rdata=0, stall=0, busy_o=0;
  - pipeline valid bits cleared, beat_cnt=0.
  - RAM contents are not reset.
- **Reset mid-operation:** all in-flight requests are dropped; no ack is ever issued for them.
- **Ack latency:** a request accepted at the edge ending cycle N has ack=1 during cycle N+LATENCY, provided cyc stays high through cycle N+LATENCY.
- **rdata:** 0 whenever ack=0.
- **Simultaneous accept and ack in the same cycle:** legal; the pipeline shifts and loads at the same edge.
- **Throughput:** 1 request/cycle with stalling disabled. With STALL_PERIOD=P: P requests per P+1 cycles under continuous stb.
- **Stall state machine:**
  - COUNT state: beat_cnt < P.
  - STALL state: beat_cnt == P; stall=1.
  - STALL → COUNT unconditionally after one cycle.

## Test plan
- **Full write, then read (LATENCY=1):** write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10 → each ack arrives the cycle after its accept; read ack carries rdata=0xDEADBEEF.
- **Byte-lane write:** write 0x00AA0000 with sel=4'b0100 to 0x10, then read → 0xDEAABEEF. A write with sel=0 still acks and leaves the word at 0xDEAABEEF.
- **Pipelined reads (LATENCY=3):** preload 0x0,0x4,0x8,0xC with 1,2,3,4, then issue 4 back-to-back reads → 4 consecutive acks, the first 3 cycles after the first accept, rdata=1,2,3,4 in order. Also check the alias: a read of 0x1010 (DEPTH_WORDS=1024) returns the word at 0x10.
- **Periodic stall (STALL_PERIOD=2):** hold stb for 4 beats → stall=1 for one cycle after the 2nd accept; 4 accepts in 5 cycles; exactly 4 acks.
- **Abort (LATENCY=3):** 2 reads accepted, then cyc dropped the next cycle → no ack ever, busy_o=0 one edge later. A new cycle then reads correctly with normal latency.
- **Async reset with 2 requests in flight:** assert reset → ack, stall and busy_o go to 0 without waiting for a clock edge. After release, a read returns previously written data.
